// File: rtl/hazard_fwd_unit_if.sv
// Pipeline hazard/forwarding bundle: ID operands and stage metadata in,
// resolved operands and stall controls out.
`timescale 1ns/1ps
interface hazard_fwd_unit_if #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5
);
    logic [RAW-1:0]  id_rs1;
    logic [RAW-1:0]  id_rs2;
    logic [6:0]      id_type;
    logic [6:0]      ex_type;
    logic [6:0]      mem_type;
    logic [6:0]      wb_type;
    logic [RAW-1:0]  ex_rd;
    logic [RAW-1:0]  mem_rd;
    logic [RAW-1:0]  wb_rd;
    logic [XLEN-1:0] id_reg1;
    logic [XLEN-1:0] id_reg2;
    logic [XLEN-1:0] ex_alu;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] mem_out;
    logic [XLEN-1:0] wb_data;
    logic            dmem_ready;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;
    logic            stall_id;
    logic            bubble_ex;
    logic            stall_all;

    modport master (
        output id_rs1, id_rs2, id_type, ex_type, mem_type, wb_type,
               ex_rd, mem_rd, wb_rd, id_reg1, id_reg2,
               ex_alu, ex_pc, mem_out, wb_data, dmem_ready,
        input  fwd1, fwd2, stall_id, bubble_ex, stall_all
    );

    modport slave (
        input  id_rs1, id_rs2, id_type, ex_type, mem_type, wb_type,
               ex_rd, mem_rd, wb_rd, id_reg1, id_reg2,
               ex_alu, ex_pc, mem_out, wb_data, dmem_ready,
        output fwd1, fwd2, stall_id, bubble_ex, stall_all
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding (EX > MEM > WB > regfile) plus load-use / memory-wait stall FSM.
// Optional stall counters enabled by defining HAZARD_PERF_CNT_EN.
`timescale 1ns/1ps
module hazard_fwd_unit #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RAW  = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_fwd_unit_if.slave     bus
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]          lu_stall_cnt,
    output logic [31:0]          mem_stall_cnt
`endif
);

    localparam logic [6:0] OP_RR     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t state, state_nxt;

    function automatic logic is_writer(input logic [6:0] op);
        return op inside {OP_RR, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_LOAD};
    endfunction

    logic            ex_wr, mem_wr, wb_wr;
    logic            ex_is_load, ex_is_link, mem_is_load;
    logic [XLEN-1:0] ex_fwd_val;
    logic [RAW-1:0]  src_idx [2];
    logic [XLEN-1:0] src_reg [2];
    logic [XLEN-1:0] src_res [2];
    logic [1:0]      src_used;
    logic [1:0]      ex_hit, mem_hit, wb_hit;
    logic            lu_hazard;

    assign ex_wr       = is_writer(bus.ex_type)  && (bus.ex_rd  != '0);
    assign mem_wr      = is_writer(bus.mem_type) && (bus.mem_rd != '0);
    assign wb_wr       = is_writer(bus.wb_type)  && (bus.wb_rd  != '0);
    assign ex_is_load  = (bus.ex_type == OP_LOAD);
    assign mem_is_load = (bus.mem_type == OP_LOAD);
    assign ex_is_link  = (bus.ex_type == OP_JAL) || (bus.ex_type == OP_JALR);
    assign ex_fwd_val  = ex_is_link ? (bus.ex_pc + XLEN'(4)) : bus.ex_alu;

    assign src_idx[0]  = bus.id_rs1;
    assign src_idx[1]  = bus.id_rs2;
    assign src_reg[0]  = bus.id_reg1;
    assign src_reg[1]  = bus.id_reg2;
    assign src_used[0] = !(bus.id_type inside {OP_LUI, OP_AUIPC, OP_JAL});
    assign src_used[1] = bus.id_type inside {OP_RR, OP_BRANCH, OP_STORE};

    // A load still in EX has no data yet: that channel keeps the regfile value
    // and the stall logic below takes care of replaying it from MEM.
    always_comb begin
        ex_hit  = '0;
        mem_hit = '0;
        wb_hit  = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            ex_hit[ch]  = src_used[ch] && ex_wr  && (src_idx[ch] == bus.ex_rd);
            mem_hit[ch] = src_used[ch] && mem_wr && (src_idx[ch] == bus.mem_rd);
            wb_hit[ch]  = src_used[ch] && wb_wr  && (src_idx[ch] == bus.wb_rd);
            if (ex_hit[ch]) begin
                src_res[ch] = ex_is_load ? src_reg[ch] : ex_fwd_val;
            end else if (mem_hit[ch]) begin
                src_res[ch] = bus.mem_out;
            end else if (wb_hit[ch]) begin
                src_res[ch] = bus.wb_data;
            end else begin
                src_res[ch] = src_reg[ch];
            end
        end
    end

    assign lu_hazard = ex_is_load && (|ex_hit);
    assign bus.fwd1  = src_res[0];
    assign bus.fwd2  = src_res[1];

    logic stall_id_c, bubble_ex_c, stall_all_c;

    always_comb begin
        stall_id_c  = 1'b0;
        bubble_ex_c = 1'b0;
        stall_all_c = 1'b0;
        state_nxt   = state;
        unique case (state)
            RUN: begin
                if (lu_hazard) begin
                    stall_id_c  = 1'b1;
                    bubble_ex_c = 1'b1;
                    state_nxt   = LU_STALL;
                end else if (mem_is_load && !bus.dmem_ready) begin
                    stall_all_c = 1'b1;
                    state_nxt   = MEM_WAIT;
                end
            end
            LU_STALL: begin
                if (bus.dmem_ready) begin
                    state_nxt   = RUN;
                end else begin
                    stall_all_c = 1'b1;
                    state_nxt   = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                if (bus.dmem_ready) begin
                    state_nxt   = RUN;
                end else begin
                    stall_all_c = 1'b1;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // Controls are Mealy; gating with rst_n drops them the instant reset asserts.
    assign bus.stall_id  = rst_n & stall_id_c;
    assign bus.bubble_ex = rst_n & bubble_ex_c;
    assign bus.stall_all = rst_n & stall_all_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lu_stall_cnt  <= '0;
            mem_stall_cnt <= '0;
        end else begin
            if (bus.bubble_ex && (lu_stall_cnt != '1)) begin
                lu_stall_cnt <= lu_stall_cnt + 32'd1;
            end
            if (bus.stall_all && (mem_stall_cnt != '1)) begin
                mem_stall_cnt <= mem_stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Scoreboard bench for hazard_fwd_unit: directed vectors plus a randomized phase
// checked against a behavioural reference model.
`timescale 1ns/1ps
module tb_hazard_fwd_unit;

    localparam logic [6:0] OP_RR     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_NONE   = 7'b0000000;

    localparam logic [31:0] R1 = 32'hAAAA_0001;
    localparam logic [31:0] R2 = 32'hBBBB_0002;
    localparam logic [31:0] MO = 32'h0000_00D0;
    localparam logic [31:0] WB = 32'h0000_00B0;
    localparam logic [31:0] EA = 32'h0000_00E0;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_fwd_unit_if #(.XLEN(32), .RAW(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] lu_cnt, mem_cnt;
`endif

    hazard_fwd_unit #(.XLEN(32), .RAW(5)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .lu_stall_cnt  (lu_cnt),
        .mem_stall_cnt (mem_cnt)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] f1;
        logic [31:0] f2;
        logic        sid;
        logic        bex;
        logic        sall;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned m_lu   = 0;
    int unsigned m_mem  = 0;
    int          m_state = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] f1, input logic [31:0] f2,
                              input logic sid, input logic bex, input logic sall);
        exp_t e;
        e.tag = tag; e.f1 = f1; e.f2 = f2; e.sid = sid; e.bex = bex; e.sall = sall;
        sb.push_back(e);
    endtask

    task automatic compare_now();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_val({e.tag, ".fwd1"}, bus.fwd1, e.f1);
            check_val({e.tag, ".fwd2"}, bus.fwd2, e.f2);
            check_val({e.tag, ".stall_id"},  {31'b0, bus.stall_id},  {31'b0, e.sid});
            check_val({e.tag, ".bubble_ex"}, {31'b0, bus.bubble_ex}, {31'b0, e.bex});
            check_val({e.tag, ".stall_all"}, {31'b0, bus.stall_all}, {31'b0, e.sall});
            if (rst_n) begin
                if (e.bex)  m_lu++;
                if (e.sall) m_mem++;
            end
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        compare_now();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
`ifdef HAZARD_PERF_CNT_EN
        check_val({tag, ".lu_cnt"},  lu_cnt,  m_lu);
        check_val({tag, ".mem_cnt"}, mem_cnt, m_mem);
`endif
    endtask

    task automatic clear();
        bus.id_rs1 = '0;  bus.id_rs2 = '0;  bus.id_type = OP_RR;
        bus.ex_type = OP_STORE; bus.mem_type = OP_STORE; bus.wb_type = OP_STORE;
        bus.ex_rd = '0;   bus.mem_rd = '0;  bus.wb_rd = '0;
        bus.id_reg1 = R1; bus.id_reg2 = R2;
        bus.ex_alu = EA;  bus.ex_pc = 32'h100; bus.mem_out = MO; bus.wb_data = WB;
        bus.dmem_ready = 1'b1;
    endtask

    function automatic logic writes(input logic [6:0] op);
        return (op == OP_RR) || (op == OP_IMM) || (op == OP_LUI) || (op == OP_AUIPC) ||
               (op == OP_JAL) || (op == OP_JALR) || (op == OP_LOAD);
    endfunction

    function automatic logic [31:0] ref_fwd(input logic [4:0] rs, input logic used,
                                            input logic [31:0] regv, output logic lu);
        lu = 1'b0;
        if (!used || rs == 5'd0) return regv;
        if (writes(bus.ex_type) && bus.ex_rd == rs) begin
            if (bus.ex_type == OP_LOAD) begin
                lu = 1'b1;
                return regv;
            end
            if (bus.ex_type == OP_JAL || bus.ex_type == OP_JALR) return bus.ex_pc + 32'd4;
            return bus.ex_alu;
        end
        if (writes(bus.mem_type) && bus.mem_rd == rs) return bus.mem_out;
        if (writes(bus.wb_type) && bus.wb_rd == rs) return bus.wb_data;
        return regv;
    endfunction

    task automatic model_step(output logic [31:0] f1, output logic [31:0] f2,
                              output logic sid, output logic bex, output logic sall,
                              output int nxt);
        logic u1, u2, lu1, lu2;
        u1 = !(bus.id_type == OP_LUI || bus.id_type == OP_AUIPC || bus.id_type == OP_JAL);
        u2 = (bus.id_type == OP_RR || bus.id_type == OP_BRANCH || bus.id_type == OP_STORE);
        f1 = ref_fwd(bus.id_rs1, u1, bus.id_reg1, lu1);
        f2 = ref_fwd(bus.id_rs2, u2, bus.id_reg2, lu2);
        sid = 1'b0; bex = 1'b0; sall = 1'b0; nxt = m_state;
        if (m_state == 0) begin
            if (lu1 || lu2) begin
                sid = 1'b1; bex = 1'b1; nxt = 1;
            end else if (bus.mem_type == OP_LOAD && !bus.dmem_ready) begin
                sall = 1'b1; nxt = 2;
            end
        end else begin
            if (bus.dmem_ready) nxt = 0;
            else begin
                sall = 1'b1; nxt = 2;
            end
        end
    endtask

    function automatic logic [6:0] pick_op();
        case ($urandom_range(0, 9))
            0: return OP_RR;     1: return OP_IMM;   2: return OP_LOAD;
            3: return OP_STORE;  4: return OP_BRANCH; 5: return OP_JAL;
            6: return OP_JALR;   7: return OP_LUI;   8: return OP_AUIPC;
            default: return OP_NONE;
        endcase
    endfunction

    initial begin
        logic [31:0] f1, f2;
        logic        sid, bex, sall;
        int          nxt;

        // Reset: controls forced low even with stall conditions present
        clear();
        bus.mem_type = OP_LOAD; bus.dmem_ready = 1'b0;
        bus.ex_type = OP_RR; bus.ex_rd = 5'd3; bus.id_rs1 = 5'd3;
        expect_out("rst_fwd", EA, R2, 1'b0, 1'b0, 1'b0); cyc();
        bus.ex_type = OP_LOAD;
        expect_out("rst_lu", R1, R2, 1'b0, 1'b0, 1'b0); cyc();
        check_cnt("rst");
        rst_n = 1'b1;

        clear();
        bus.ex_type = OP_RR; bus.ex_rd = 5'd3; bus.ex_alu = 32'h11;
        bus.id_rs1 = 5'd3; bus.id_type = OP_IMM;
        expect_out("ex_alu", 32'h11, R2, 1'b0, 1'b0, 1'b0); cyc();

        // Same destination in every stage: youngest wins, then fall-through
        clear();
        bus.ex_type = OP_RR; bus.mem_type = OP_LOAD; bus.wb_type = OP_IMM;
        bus.ex_rd = 5'd7; bus.mem_rd = 5'd7; bus.wb_rd = 5'd7;
        bus.id_rs2 = 5'd7; bus.id_type = OP_STORE;
        expect_out("prio_ex", R1, EA, 1'b0, 1'b0, 1'b0); cyc();
        bus.ex_rd = 5'd0;
        expect_out("prio_mem", R1, MO, 1'b0, 1'b0, 1'b0); cyc();
        bus.ex_rd = 5'd7; bus.ex_type = OP_BRANCH;
        expect_out("nonwriter_ex", R1, MO, 1'b0, 1'b0, 1'b0); cyc();
        bus.mem_rd = 5'd0;
        expect_out("prio_wb", R1, WB, 1'b0, 1'b0, 1'b0); cyc();
        bus.id_type = OP_IMM;
        expect_out("rs2_unused", R1, R2, 1'b0, 1'b0, 1'b0); cyc();

        clear();
        bus.ex_type = OP_JAL; bus.ex_rd = 5'd1; bus.ex_pc = 32'hFFFF_FFFC;
        bus.id_rs1 = 5'd1; bus.id_type = OP_JALR;
        expect_out("jal_wrap", 32'h0, R2, 1'b0, 1'b0, 1'b0); cyc();
        bus.ex_type = OP_JALR; bus.ex_pc = 32'h100;
        expect_out("jalr_link", 32'h104, R2, 1'b0, 1'b0, 1'b0); cyc();
        bus.id_type = OP_LUI;
        expect_out("lui_rs1", R1, R2, 1'b0, 1'b0, 1'b0); cyc();

        // Load-use, data ready on the replay cycle
        clear();
        bus.ex_type = OP_LOAD; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.dmem_ready = 1'b0;
        expect_out("lu_c1", R1, R2, 1'b1, 1'b1, 1'b0); cyc();
        bus.ex_type = OP_IMM; bus.ex_rd = 5'd0; bus.mem_type = OP_LOAD; bus.mem_rd = 5'd5;
        bus.dmem_ready = 1'b1;
        expect_out("lu_c2", MO, R2, 1'b0, 1'b0, 1'b0); cyc();
        bus.ex_type = OP_LOAD; bus.ex_rd = 5'd5; bus.mem_type = OP_STORE; bus.mem_rd = 5'd0;
        bus.dmem_ready = 1'b0;
        expect_out("lu_again", R1, R2, 1'b1, 1'b1, 1'b0); cyc();
        // Load-use followed by three wait cycles; hazard is ignored while frozen
        bus.ex_type = OP_IMM; bus.ex_rd = 5'd0; bus.mem_type = OP_LOAD; bus.mem_rd = 5'd5;
        expect_out("wait1", MO, R2, 1'b0, 1'b0, 1'b1); cyc();
        bus.ex_type = OP_LOAD; bus.ex_rd = 5'd5;
        expect_out("wait2", R1, R2, 1'b0, 1'b0, 1'b1); cyc();
        expect_out("wait3", R1, R2, 1'b0, 1'b0, 1'b1); cyc();
        bus.dmem_ready = 1'b1;
        expect_out("wait_rel", R1, R2, 1'b0, 1'b0, 1'b0); cyc();
        expect_out("reeval", R1, R2, 1'b1, 1'b1, 1'b0); cyc();
        clear();
        expect_out("lu_done", R1, R2, 1'b0, 1'b0, 1'b0); cyc();
        check_cnt("mid");

        // Asynchronous reset while in MEM_WAIT
        bus.mem_type = OP_LOAD; bus.dmem_ready = 1'b0;
        expect_out("mw_enter", R1, R2, 1'b0, 1'b0, 1'b1); cyc();
        expect_out("mw_hold", R1, R2, 1'b0, 1'b0, 1'b1); cyc();
        #2;
        rst_n = 1'b0; m_lu = 0; m_mem = 0;
        #1;
        expect_out("async_rst", R1, R2, 1'b0, 1'b0, 1'b0);
        compare_now();
        check_cnt("async_rst");
        clear();
        expect_out("rst_hold", R1, R2, 1'b0, 1'b0, 1'b0); cyc();
        rst_n = 1'b1;
        bus.ex_type = OP_LOAD; bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5;
        expect_out("post_rst_run", R1, R2, 1'b1, 1'b1, 1'b0); cyc();
        clear();
        expect_out("post_rst_rel", R1, R2, 1'b0, 1'b0, 1'b0); cyc();
        m_state = 0;

        for (int i = 0; i < 400; i++) begin
            bus.id_rs1 = 5'($urandom_range(0, 3)); bus.id_rs2 = 5'($urandom_range(0, 3));
            bus.ex_rd  = 5'($urandom_range(0, 3)); bus.mem_rd = 5'($urandom_range(0, 3));
            bus.wb_rd  = 5'($urandom_range(0, 3));
            bus.id_type = pick_op(); bus.ex_type = pick_op();
            bus.mem_type = pick_op(); bus.wb_type = pick_op();
            bus.id_reg1 = $urandom; bus.id_reg2 = $urandom;
            bus.ex_alu = $urandom; bus.mem_out = $urandom; bus.wb_data = $urandom;
            bus.ex_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFC : $urandom;
            bus.dmem_ready = ($urandom_range(0, 9) < 7);
            model_step(f1, f2, sid, bex, sall, nxt);
            expect_out($sformatf("rnd%0d", i), f1, f2, sid, bex, sall);
            cyc();
            m_state = nxt;
        end
        check_cnt("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
